// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer.
// Holds the FSM encoding, BCD limits and a per-digit BCD helper.
package reaction_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] BCD_MAX   = 16'h9999;
    localparam logic [15:0] BEST_INIT = 16'h9999;

    // Increment one BCD digit; bit 4 is the carry out (digit wrapped 9 -> 0).
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
        logic [4:0] r;
        if (d >= 4'd9) begin
            r = 5'b1_0000;
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_inc4.sv
// Four-digit BCD incrementer with saturation at 9999.
// Purely combinational; output equals input when saturated.
module bcd_inc4
    import reaction_timer_pkg::*;
(
    input  logic [15:0] bcd_i,
    output logic [15:0] bcd_o,
    output logic        sat_o
);

    logic [15:0] sum;

    // Ripple a carry through the four digits, least significant first.
    always_comb begin
        logic       carry;
        logic [4:0] r;
        sum   = bcd_i;
        carry = 1'b1;
        r     = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                r            = bcd_digit_inc(bcd_i[4*i +: 4]);
                sum[4*i +: 4] = r[3:0];
                carry        = r[4];
            end
        end
    end

    assign sat_o = (bcd_i == BCD_MAX);
    assign bcd_o = sat_o ? bcd_i : sum;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: counts milliseconds in BCD until the player presses.
// Tracks the best (lowest) non-overflow time since reset.
module reaction_timer
    import reaction_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        en_counter,
    input  logic        reset_counter,
    input  logic        button,
    output logic        stop_counter,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic [15:0] best,
    output logic        new_best
);

    logic        sync1_q;
    logic        sync2_q;
    logic        prev_q;
    logic [1:0]  fill_q;
    logic        arm_q;
    logic        arm_d;
    logic        press_q;
    logic        press_d;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] bcd_q;
    logic [15:0] bcd_d;
    logic        ovf_q;
    logic        ovf_d;
    logic [15:0] best_q;
    logic [15:0] best_d;
    logic        stop_q;
    logic        stop_d;
    logic        nb_q;
    logic        nb_d;

    logic [15:0] bcd_inc;
    logic        bcd_sat;

    // A press needs a low level seen after reset, so a key held through reset is not a press.
    assign arm_d   = arm_q | (fill_q[1] & ~sync2_q);
    assign press_d = sync2_q & ~prev_q & arm_q;

    // Two-flop synchronizer, rising-edge detector and registered press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'b00;
            arm_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            arm_q   <= arm_d;
            press_q <= press_d;
        end
    end

    bcd_inc4 u_inc (
        .bcd_i (bcd_q),
        .bcd_o (bcd_inc),
        .sat_o (bcd_sat)
    );

    // Next state: a press beats a tick, and a falling enable aborts quietly.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        best_d  = best_q;
        stop_d  = 1'b0;
        nb_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reset_counter) begin
                    bcd_d = 16'h0000;
                    ovf_d = 1'b0;
                end
                if (en_counter) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (press_q) begin
                    state_d = HOLD;
                    stop_d  = 1'b1;
                    if (bcd_q < best_q) begin
                        best_d = bcd_q;
                        nb_d   = 1'b1;
                    end
                end else if (!en_counter) begin
                    state_d = IDLE;
                end else if (tick_ms) begin
                    if (bcd_sat) begin
                        ovf_d   = 1'b1;
                        stop_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        bcd_d = bcd_inc;
                    end
                end
            end
            HOLD: begin
                if (!en_counter) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Measurement state, result and best-time registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            best_q  <= BEST_INIT;
            stop_q  <= 1'b0;
            nb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            best_q  <= best_d;
            stop_q  <= stop_d;
            nb_q    <= nb_d;
        end
    end

    assign stop_counter = stop_q;
    assign bcd          = bcd_q;
    assign overflow     = ovf_q;
    assign best         = best_q;
    assign new_best     = nb_q;

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 The block SHALL use a single clock, and its reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick_ms, input, 1 bit: one-clk strobe, once per millisecond.
REQ-005 The block SHALL have port en_counter, input, 1 bit: level from the sequencing FSM; high = measurement window open.
REQ-006 The block SHALL have port reset_counter, input, 1 bit: level from the sequencing FSM; high = clear result.
REQ-007 The block SHALL have port button, input, 1 bit: raw, debounced, asynchronous, active-high player key.
REQ-008 The block SHALL have port stop_counter, output, 1 bit: one-clk pulse ending the measurement; feeds the sequencing FSM.
REQ-009 The block SHALL have port bcd, output, 16 bits: current/held reaction time, 4 BCD digits, ms, [15:12] = thousands.
REQ-010 The block SHALL have port overflow, output, 1 bit: high when the measurement saturated at 9999.
REQ-011 The block SHALL have port best, output, 16 bits: best (lowest) non-overflow time since reset, 4 BCD digits.
REQ-012 The block SHALL have port new_best, output, 1 bit: one-clk pulse when best is updated.

Function
REQ-013 button SHALL pass through a 2-flop synchronizer, then a rising-edge detector; press = registered edge pulse.
REQ-014 The FSM SHALL have states IDLE, RUN, HOLD.
REQ-015 IDLE: reset_counter=1 SHALL clear bcd to 16'h0000 and overflow to 0 on the next edge; en_counter=1 SHALL move to RUN.
REQ-016 RUN: each tick_ms SHALL increment bcd by 1 in BCD; a digit at 9 wraps to 0 with carry into the next digit.
REQ-017 RUN: tick_ms with bcd=16'h9999 SHALL hold bcd, set overflow=1, pulse stop_counter, and enter HOLD.
REQ-018 RUN: a press SHALL freeze bcd, pulse stop_counter for exactly one clk, and enter HOLD.
REQ-019 Latency: raw button rising at edge N SHALL produce stop_counter high during cycle N+3.
REQ-020 A press and tick_ms in the same cycle: the press SHALL win; the tick SHALL not be counted.
REQ-021 A press and the 9999 saturating tick in the same cycle SHALL be treated as a press; overflow SHALL stay 0.
REQ-022 On a press-stop with bcd < best (numeric BCD compare), best SHALL load bcd on the HOLD-entry edge, with new_best pulsing one clk.
REQ-023 Equal or greater times, and overflow stops, SHALL leave best unchanged.
REQ-024 HOLD: bcd and overflow SHALL hold; en_counter=0 SHALL return to IDLE.
REQ-025 Presses in IDLE or HOLD SHALL be ignored; no stop_counter.
REQ-026 reset_counter in RUN SHALL be ignored.
REQ-027 en_counter falling in RUN without a press SHALL return to IDLE, holding bcd, with no stop_counter and no best update.
REQ-028 stop_counter SHALL never be high in two consecutive cycles.

Reset
REQ-029 rst SHALL immediately force the FSM to IDLE, bcd=16'h0000, overflow=0, best=16'h9999, stop_counter=0, new_best=0, and synchronizer/edge flops to 0.
REQ-030 rst asserted in RUN SHALL abort the measurement with no stop_counter pulse.
REQ-031 After rst release, a button already held high SHALL not register as a press.

Structure
REQ-032 The state encoding (IDLE/RUN/HOLD), BCD_MAX=16'h9999, and BEST_INIT=16'h9999 SHALL live in the shared package.
REQ-033 A 4-digit BCD incrementer with saturate flag SHALL be sub-module bcd_inc4, combinational, 16-bit in, 16-bit out plus sat.

Verification
REQ-034 Reset, then en_counter=1, 237 tick_ms, press -> bcd=16'h0237, one stop_counter pulse 3 clks after press, best=16'h0237, new_best pulse.
REQ-035 Next run of 412 ticks then press -> bcd=16'h0412, best stays 16'h0237, no new_best.
REQ-036 Run of 10000 ticks, no press -> bcd=16'h9999, overflow=1, one stop_counter, best unchanged.
REQ-037 Synchronized press coincident with the 100th tick -> bcd=16'h0099.
REQ-038 rst asserted mid-RUN at bcd=16'h0050 -> all outputs at reset values, no stop_counter.
REQ-039 Press in IDLE and in HOLD, and reset_counter in RUN -> no stop_counter, bcd unchanged.
